// File: rtl/rx_payload_buffer_pkg.sv
// Shared types and constants for the two-bank UDP payload buffer.
// Optional drop counter: RX_BUF_DROP_CNT_EN.
package rx_payload_buffer_pkg;

  localparam int OCT = 8;
  localparam int DEF_BANK_AW = 11;

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL
  } bank_st_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_RECV,
    WR_DROP
  } wr_st_t;

endpackage

// File: rtl/rx_payload_buffer_if.sv
// Payload stream in, packet read path out.
// master = parser/software side, slave = buffer.
interface rx_payload_buffer_if
  import rx_payload_buffer_pkg::*;
#(
  parameter int BANK_AW = DEF_BANK_AW
) ();

  logic               rx_udp_data_v;
  logic [OCT-1:0]     rx_udp_data;
  logic               rx_udp_sof;
  logic               rx_udp_eof;
  logic               rx_udp_err;
  logic [BANK_AW-1:0] rd_addr;
  logic [OCT-1:0]     rd_data;
  logic               rx_ready;
  logic [BANK_AW:0]   rx_len;
  logic               rx_release;

  modport master (
    output rx_udp_data_v,
    output rx_udp_data,
    output rx_udp_sof,
    output rx_udp_eof,
    output rx_udp_err,
    output rd_addr,
    output rx_release,
    input  rd_data,
    input  rx_ready,
    input  rx_len
  );

  modport slave (
    input  rx_udp_data_v,
    input  rx_udp_data,
    input  rx_udp_sof,
    input  rx_udp_eof,
    input  rx_udp_err,
    input  rd_addr,
    input  rx_release,
    output rd_data,
    output rx_ready,
    output rx_len
  );

endinterface

// File: rtl/rx_buf_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Drop-in replaceable by a hard macro.
module rx_buf_ram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_payload_buffer.sv
// Two-bank UDP payload buffer: commit on clean eof, serve oldest packet.
// Optional drop counter: RX_BUF_DROP_CNT_EN.
module rx_payload_buffer
  import rx_payload_buffer_pkg::*;
#(
  parameter int BANK_AW = DEF_BANK_AW
) (
  input logic wb_clk_i,
  input logic wb_rst_n,
  rx_payload_buffer_if.slave bus
`ifdef RX_BUF_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  bank_st_t           bank_st [2];
  logic [BANK_AW:0]   len [2];
  logic               wr_bank;
  logic               rd_bank;
  wr_st_t             wr_st;
  logic [BANK_AW:0]   cnt;

  logic               v;
  logic               eof;
  logic               err;
  logic               start;
  logic               in_recv;
  logic               avail;
  logic               ovf;
  logic               ready;
  logic               rel_ok;
  logic               we;
  logic [BANK_AW-1:0] woff;
  logic [OCT-1:0]     rd_q;

  assign v       = bus.rx_udp_data_v;
  assign eof     = bus.rx_udp_eof;
  assign err     = bus.rx_udp_err;
  assign start   = v & bus.rx_udp_sof;
  assign in_recv = (wr_st == WR_RECV);
  // a restart inside RECV reuses the bank it already holds
  assign avail   = in_recv |
                   (bank_st[wr_bank] == BANK_FREE);
  assign ovf     = cnt[BANK_AW];
  assign we      = start ? avail
                         : (v & in_recv & ~ovf);
  assign woff    = start ? '0 : cnt[BANK_AW-1:0];

  assign ready  = (bank_st[rd_bank] == BANK_FULL);
  assign rel_ok = bus.rx_release & ready;

  assign bus.rx_ready = ready;
  assign bus.rx_len   = ready ? len[rd_bank] : '0;
  assign bus.rd_data  = rd_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bank_st[0] <= BANK_FREE;
      bank_st[1] <= BANK_FREE;
      len[0]     <= '0;
      len[1]     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_st      <= WR_IDLE;
      cnt        <= '0;
    end else begin
      if (start) begin
        if (!avail) begin
          wr_st <= eof ? WR_IDLE : WR_DROP;
        end else if (err) begin
          bank_st[wr_bank] <= BANK_FREE;
          cnt              <= '0;
          wr_st            <= eof ? WR_IDLE : WR_DROP;
        end else if (eof) begin
          bank_st[wr_bank] <= BANK_FULL;
          len[wr_bank]     <= (BANK_AW+1)'(1);
          wr_bank          <= ~wr_bank;
          cnt              <= '0;
          wr_st            <= WR_IDLE;
        end else begin
          bank_st[wr_bank] <= BANK_FILLING;
          cnt              <= (BANK_AW+1)'(1);
          wr_st            <= WR_RECV;
        end
      end else if (v) begin
        unique case (wr_st)
          WR_RECV: begin
            if (err | ovf) begin
              bank_st[wr_bank] <= BANK_FREE;
              cnt              <= '0;
              wr_st            <= eof ? WR_IDLE
                                      : WR_DROP;
            end else if (eof) begin
              bank_st[wr_bank] <= BANK_FULL;
              len[wr_bank]     <= cnt + 1'b1;
              wr_bank          <= ~wr_bank;
              cnt              <= '0;
              wr_st            <= WR_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR_DROP: begin
            if (eof) wr_st <= WR_IDLE;
          end
          default: ;
        endcase
      end
      // never collides with the write side: rd bank is FULL here
      if (rel_ok) begin
        bank_st[rd_bank] <= BANK_FREE;
        rd_bank          <= ~rd_bank;
      end
    end
  end

`ifdef RX_BUF_DROP_CNT_EN
  logic drop_ev;

  assign drop_ev = start
    ? (in_recv | ~avail | err)
    : (v & in_recv & (err | ovf));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      drop_cnt <= '0;
    end else if (drop_ev && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  rx_buf_ram #(
    .AW (BANK_AW + 1),
    .DW (OCT)
  ) u_ram (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .we    (we),
    .waddr ({wr_bank, woff}),
    .wdata (bus.rx_udp_data),
    .raddr ({rd_bank, bus.rd_addr}),
    .rdata (rd_q)
  );

endmodule
